// File: rtl/fetch_unit.sv
// Instruction-fetch / memory-interface datapath: PC, MAR, MBR and IR, all
// loaded on control-unit strobes, plus PC-wrap and retired-fetch status.
module fetch_unit #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [3:0]  DATA_PAGE = 4'hF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              FU_clk,
    input  logic              FU_rst_n,
    input  logic              MAR_we,
    input  logic              MAR_mux,
    input  logic              MBR_we,
    input  logic              MBR_mux,
    input  logic              IR_we,
    input  logic              PC_inc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  logic [7:0]        ram_rdata,
    input  logic [7:0]        rf_rdata,
    output logic [ADDR_W-1:0] mar_addr,
    output logic [7:0]        mbr_data,
    output logic [7:0]        ir_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_wrap,
    output logic [CNT_W-1:0]  fetch_cnt
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mar_q;
    logic [7:0]        mbr_q;
    logic [7:0]        ir_q;
    logic              wrap_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] oper_addr;

    // Direct LD/ST operand address lives in a fixed data page.
    assign oper_addr = ADDR_W'({DATA_PAGE, ir_q[3:0]});

    always_ff @(posedge FU_clk or negedge FU_rst_n) begin
        if (!FU_rst_n) begin
            mar_q <= '0;
        end else if (MAR_we) begin
            mar_q <= MAR_mux ? oper_addr : pc_q;
        end
    end

    always_ff @(posedge FU_clk or negedge FU_rst_n) begin
        if (!FU_rst_n) begin
            mbr_q <= '0;
        end else if (MBR_we) begin
            mbr_q <= MBR_mux ? rf_rdata : ram_rdata;
        end
    end

    always_ff @(posedge FU_clk or negedge FU_rst_n) begin
        if (!FU_rst_n) begin
            ir_q <= '0;
        end else if (IR_we) begin
            ir_q <= mbr_q;
        end
    end

    // A jump load takes priority over increment and never counts as a wrap.
    always_ff @(posedge FU_clk or negedge FU_rst_n) begin
        if (!FU_rst_n) begin
            pc_q   <= '0;
            wrap_q <= 1'b0;
        end else if (pc_load) begin
            pc_q <= pc_load_val;
        end else if (PC_inc) begin
            pc_q <= pc_q + ADDR_W'(1);
            if (pc_q == '1) begin
                wrap_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge FU_clk or negedge FU_rst_n) begin
        if (!FU_rst_n) begin
            cnt_q <= '0;
        end else if (IR_we && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign mar_addr  = mar_q;
    assign mbr_data  = mbr_q;
    assign ir_out    = ir_q;
    assign pc_out    = pc_q;
    assign pc_wrap   = wrap_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset/corner sequences and a
// randomized run against a behavioural model (second instance has a 4-bit counter).
module tb_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       mar_we, mar_mux, mbr_we, mbr_mux, ir_we, pc_inc, pc_load;
    logic [7:0] pc_load_val, rf_rdata, ram_rdata, s_ram_rdata;
    logic [7:0] mar_addr, mbr_data, ir_out, pc_out;
    logic       pc_wrap;
    logic [15:0] fetch_cnt;
    logic [7:0] s_mar, s_mbr, s_ir, s_pc;
    logic       s_wrap;
    logic [3:0] s_cnt;

    logic [7:0] ram [256];
    int errors = 0;
    int checks = 0;

    assign ram_rdata   = ram[mar_addr];
    assign s_ram_rdata = ram[s_mar];

    fetch_unit #(.ADDR_W(8), .DATA_PAGE(4'hF), .CNT_W(16)) dut (
        .FU_clk(clk), .FU_rst_n(rst_n),
        .MAR_we(mar_we), .MAR_mux(mar_mux), .MBR_we(mbr_we), .MBR_mux(mbr_mux),
        .IR_we(ir_we), .PC_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .ram_rdata(ram_rdata), .rf_rdata(rf_rdata),
        .mar_addr(mar_addr), .mbr_data(mbr_data), .ir_out(ir_out), .pc_out(pc_out),
        .pc_wrap(pc_wrap), .fetch_cnt(fetch_cnt)
    );

    fetch_unit #(.ADDR_W(8), .DATA_PAGE(4'hF), .CNT_W(4)) dut_sat (
        .FU_clk(clk), .FU_rst_n(rst_n),
        .MAR_we(mar_we), .MAR_mux(mar_mux), .MBR_we(mbr_we), .MBR_mux(mbr_mux),
        .IR_we(ir_we), .PC_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .ram_rdata(s_ram_rdata), .rf_rdata(rf_rdata),
        .mar_addr(s_mar), .mbr_data(s_mbr), .ir_out(s_ir), .pc_out(s_pc),
        .pc_wrap(s_wrap), .fetch_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mw, mm, bw, bm, iw, pi, pl;
        logic [7:0] pv, rf;
        logic       poke;
        logic [7:0] poke_val;
        logic [7:0] e_mar, e_mbr, e_ir, e_pc;
        logic       e_wrap;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mar_we = 0; mar_mux = 0; mbr_we = 0; mbr_mux = 0;
        ir_we = 0; pc_inc = 0; pc_load = 0; pc_load_val = 0; rf_rdata = 0;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] emar, input logic [7:0] embr,
                           input logic [7:0] eir, input logic [7:0] epc, input logic ew,
                           input logic [15:0] ecnt);
        chk({tag, ".mar"},  32'(mar_addr),  32'(emar));
        chk({tag, ".mbr"},  32'(mbr_data),  32'(embr));
        chk({tag, ".ir"},   32'(ir_out),    32'(eir));
        chk({tag, ".pc"},   32'(pc_out),    32'(epc));
        chk({tag, ".wrap"}, 32'(pc_wrap),   32'(ew));
        chk({tag, ".cnt"},  32'(fetch_cnt), 32'(ecnt));
    endtask

    // Reference model state
    logic [7:0] m_pc, m_mar, m_mbr, m_ir, rd;
    logic       m_wrap;
    int         m_cnt, m_cnt4;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        ram[8'h00] = 8'h3C;
        ram[8'h01] = 8'h05;
        ram[8'h02] = 8'h22;
        ram[8'hF5] = 8'h99;

        //          mw mm bw bm iw pi pl  pv     rf    pk pkv    mar    mbr    ir     pc   wr cnt
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd0};
        tbl[1]  = '{0, 0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h01, 0, 16'd0};
        tbl[2]  = '{0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h01, 0, 16'd1};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 8'h3C, 8'h3C, 8'h01, 0, 16'd1};
        tbl[4]  = '{0, 0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 8'h05, 8'h3C, 8'h02, 0, 16'd1};
        tbl[5]  = '{0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 8'h05, 8'h05, 8'h02, 0, 16'd2};
        tbl[6]  = '{1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'hF5, 8'h05, 8'h05, 8'h02, 0, 16'd2};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'hF5, 8'h99, 8'h05, 8'h02, 0, 16'd2};
        tbl[8]  = '{0, 0, 1, 1, 0, 0, 0, 8'h00, 8'h4E, 0, 8'h00, 8'hF5, 8'h4E, 8'h05, 8'h02, 0, 16'd2};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h77, 8'hF5, 8'h4E, 8'h05, 8'h02, 0, 16'd2};
        tbl[10] = '{0, 0, 1, 1, 0, 0, 0, 8'h00, 8'h11, 0, 8'h00, 8'hF5, 8'h11, 8'h05, 8'h02, 0, 16'd2};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h02, 8'h11, 8'h05, 8'h02, 0, 16'd2};
        tbl[12] = '{0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h02, 8'h22, 8'h11, 8'h02, 0, 16'd3};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h02, 8'h22, 8'h11, 8'hFF, 0, 16'd3};
        tbl[14] = '{0, 0, 0, 0, 0, 1, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h02, 8'h22, 8'h11, 8'hFF, 0, 16'd3};
        tbl[15] = '{0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h02, 8'h22, 8'h11, 8'h00, 1, 16'd3};
        tbl[16] = '{0, 0, 0, 0, 0, 1, 1, 8'h20, 8'h00, 0, 8'h00, 8'h02, 8'h22, 8'h11, 8'h20, 1, 16'd3};
        tbl[17] = '{1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h20, 8'h22, 8'h11, 8'h21, 1, 16'd3};
        tbl[18] = '{1, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'hF1, 8'h22, 8'h22, 8'h21, 1, 16'd4};

        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 19; i++) begin
            mar_we = tbl[i].mw; mar_mux = tbl[i].mm; mbr_we = tbl[i].bw; mbr_mux = tbl[i].bm;
            ir_we = tbl[i].iw; pc_inc = tbl[i].pi; pc_load = tbl[i].pl;
            pc_load_val = tbl[i].pv; rf_rdata = tbl[i].rf;
            if (tbl[i].poke) ram[mar_addr] = tbl[i].poke_val;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_mar, tbl[i].e_mbr, tbl[i].e_ir,
                    tbl[i].e_pc, tbl[i].e_wrap, tbl[i].e_cnt);
        end

        // Reset asserted between edges with live state
        idle();
        mbr_we = 1; mbr_mux = 1; rf_rdata = 8'h12;
        tick();
        idle();
        ir_we = 1;
        tick();
        idle();
        mbr_we = 1; mbr_mux = 1; rf_rdata = 8'hA5; pc_load = 1; pc_load_val = 8'h37;
        tick();
        idle();
        chk("pre_rst.pc",  32'(pc_out),   32'h37);
        chk("pre_rst.mbr", 32'(mbr_data), 32'hA5);
        chk("pre_rst.ir",  32'(ir_out),   32'h12);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0);
        chk("async_rst.sat_cnt", 32'(s_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // First fetch after reset addresses 0x00
        mar_we = 1;
        tick();
        idle();
        chk("first_fetch.mar", 32'(mar_addr), 32'h00);

        // Randomized run against the model
        m_pc = 0; m_mar = 0; m_mbr = 0; m_ir = 0; m_wrap = 0; m_cnt = 0; m_cnt4 = 0;
        for (int c = 0; c < 400; c++) begin
            mar_we  = 1'($urandom_range(0, 1));
            mar_mux = 1'($urandom_range(0, 1));
            mbr_we  = 1'($urandom_range(0, 1));
            mbr_mux = 1'($urandom_range(0, 1));
            ir_we   = 1'($urandom_range(0, 1));
            pc_inc  = ($urandom_range(0, 3) != 0);
            pc_load = ($urandom_range(0, 15) == 0);
            pc_load_val = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            rf_rdata = 8'($urandom);

            rd = ram[m_mar];
            if (mar_we) m_mar = mar_mux ? {4'hF, m_ir[3:0]} : m_pc;
            if (ir_we) begin
                m_ir = m_mbr;
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
                m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
            end
            if (mbr_we) m_mbr = mbr_mux ? rf_rdata : rd;
            if (pc_load) begin
                m_pc = pc_load_val;
            end else if (pc_inc) begin
                if (m_pc == 8'd255) m_wrap = 1'b1;
                m_pc = 8'((int'(m_pc) + 1) % 256);
            end

            tick();
            chk_all($sformatf("rnd%0d", c), m_mar, m_mbr, m_ir, m_pc, m_wrap, 16'(m_cnt));
            chk($sformatf("rnd%0d.sat_cnt", c), 32'(s_cnt), 32'(m_cnt4));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
